// File: rtl/aes_rx_block_packer.sv
// aes_rx_block_packer
// Gathers a 32-byte frame from the UART byte receiver: 16 plaintext bytes,
// then 16 key bytes, each group MSB-first. The result is presented to the
// AES-128 core as one 128-bit plaintext and one 128-bit key.
//
// Handshake (valid/ready): blk_valid rises one clock after the 32nd byte
// strobe and stays high, with blk_plaintext/blk_key stable, until a cycle in
// which blk_valid && blk_ready. That cycle is the transfer. blk_ready is
// ignored while blk_valid is low.
//
// Inside a frame, an inter-byte timeout discards a partial frame. A byte
// that arrives while a finished frame is still unaccepted is dropped. Each
// of these events raises a one-cycle error pulse.
module aes_rx_block_packer #(
    parameter int TIMEOUT_CLKS = 17360,
    parameter int TO_W         = 15
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   rx_data,
    input  logic         rx_valid,
    output logic [127:0] blk_plaintext,
    output logic [127:0] blk_key,
    output logic         blk_valid,
    input  logic         blk_ready,
    output logic         busy,
    output logic [5:0]   byte_cnt,
    output logic         err_timeout,
    output logic         err_overrun
);

    // Last counter value that is still allowed. Reaching it with no byte
    // present means the frame has gone stale.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CLKS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PT   = 2'd1,
        ST_KEY  = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    state_t         state_q;
    state_t         state_d;
    logic [5:0]     byte_cnt_q;
    logic [5:0]     byte_cnt_d;
    logic [TO_W-1:0] to_cnt_q;
    logic [127:0]   pt_q;
    logic [127:0]   key_q;
    logic           err_to_q;
    logic           err_ov_q;

    // Per-cycle decisions made by the FSM
    logic           accept;    // rx_data is taken into the frame this cycle
    logic           expire;    // the partial frame times out this cycle
    logic           overrun;   // a byte is dropped because HOLD is blocked
    logic [4:0]     wr_idx;    // frame position the accepted byte goes to
    logic           in_frame;  // PT or KEY: the timeout is active

    assign in_frame = (state_q == ST_PT) || (state_q == ST_KEY);

    // Next state, next byte count and the accept/expire/overrun decisions
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        accept     = 1'b0;
        expire     = 1'b0;
        overrun    = 1'b0;
        wr_idx     = byte_cnt_q[4:0];
        case (state_q)
            ST_IDLE: begin
                wr_idx = 5'd0;
                if (rx_valid) begin
                    accept     = 1'b1;
                    state_d    = ST_PT;
                    byte_cnt_d = 6'd1;
                end
            end
            ST_PT: begin
                if (rx_valid) begin
                    // A byte that arrives on the expiry cycle still counts
                    accept     = 1'b1;
                    byte_cnt_d = byte_cnt_q + 6'd1;
                    if (byte_cnt_q == 6'd15) begin
                        state_d = ST_KEY;
                    end
                end else if (to_cnt_q == TO_LAST) begin
                    expire     = 1'b1;
                    state_d    = ST_IDLE;
                    byte_cnt_d = 6'd0;
                end
            end
            ST_KEY: begin
                if (rx_valid) begin
                    accept     = 1'b1;
                    byte_cnt_d = byte_cnt_q + 6'd1;
                    if (byte_cnt_q == 6'd31) begin
                        state_d = ST_HOLD;
                    end
                end else if (to_cnt_q == TO_LAST) begin
                    expire     = 1'b1;
                    state_d    = ST_IDLE;
                    byte_cnt_d = 6'd0;
                end
            end
            ST_HOLD: begin
                wr_idx = 5'd0;
                if (blk_ready) begin
                    // Handshake: a byte in the same cycle opens the next frame
                    if (rx_valid) begin
                        accept     = 1'b1;
                        state_d    = ST_PT;
                        byte_cnt_d = 6'd1;
                    end else begin
                        state_d    = ST_IDLE;
                        byte_cnt_d = 6'd0;
                    end
                end else if (rx_valid) begin
                    overrun = 1'b1;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                byte_cnt_d = 6'd0;
            end
        endcase
    end

    // State and byte count registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            byte_cnt_q <= 6'd0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
        end
    end

    // Inter-byte timeout counter: it runs only inside a frame and restarts on each byte
    always_ff @(posedge clk) begin
        if (rst || !in_frame || accept || expire) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
        end
    end

    // Frame data registers: write the accepted byte in place, wipe on timeout
    always_ff @(posedge clk) begin
        if (rst || expire) begin
            pt_q  <= '0;
            key_q <= '0;
        end else if (accept) begin
            for (int i = 0; i < 16; i++) begin
                if (!wr_idx[4] && (wr_idx[3:0] == 4'(i))) begin
                    pt_q[8*(15-i) +: 8] <= rx_data;
                end
                if (wr_idx[4] && (wr_idx[3:0] == 4'(i))) begin
                    key_q[8*(15-i) +: 8] <= rx_data;
                end
            end
        end
    end

    // One-cycle error pulses, registered from this cycle's decisions
    always_ff @(posedge clk) begin
        if (rst) begin
            err_to_q <= 1'b0;
            err_ov_q <= 1'b0;
        end else begin
            err_to_q <= expire;
            err_ov_q <= overrun;
        end
    end

    assign blk_plaintext = pt_q;
    assign blk_key       = key_q;
    assign blk_valid     = (state_q == ST_HOLD);
    assign busy          = in_frame;
    assign byte_cnt      = byte_cnt_q;
    assign err_timeout   = err_to_q;
    assign err_overrun   = err_ov_q;

endmodule

// File: tb/tb_aes_rx_block_packer.sv
// Bench for aes_rx_block_packer. A frame-level reference model is compared
// with the DUT on every clock. Directed scenarios add fixed literal checks.
module tb_aes_rx_block_packer;

    localparam int T = 17360;

    localparam logic [127:0] NOM_PT  = 128'h416476616E63656420456E6372797074;
    localparam logic [127:0] NOM_KEY = 128'h5468617473204D79204B756E67204675;

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [7:0]   rx_data = 8'h00;
    logic         rx_valid = 1'b0;
    logic         blk_ready = 1'b0;
    logic [127:0] blk_plaintext;
    logic [127:0] blk_key;
    logic         blk_valid;
    logic         busy;
    logic [5:0]   byte_cnt;
    logic         err_timeout;
    logic         err_overrun;

    always #5 clk = ~clk;

    aes_rx_block_packer #(.TIMEOUT_CLKS(T), .TO_W(15)) dut (
        .clk           (clk),
        .rst           (rst),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .blk_plaintext (blk_plaintext),
        .blk_key       (blk_key),
        .blk_valid     (blk_valid),
        .blk_ready     (blk_ready),
        .busy          (busy),
        .byte_cnt      (byte_cnt),
        .err_timeout   (err_timeout),
        .err_overrun   (err_overrun)
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // The frame is a count of received bytes plus two byte arrays. A count
    // of 32 means a finished frame is waiting. m_quiet counts the idle
    // clocks since the last byte of an unfinished frame.
    int         m_cnt   = 0;
    int         m_quiet = 0;
    logic [7:0] m_pt  [16];
    logic [7:0] m_key [16];
    logic       m_eto = 1'b0;
    logic       m_eov = 1'b0;
    bit         m_live = 1'b0;

    function automatic logic [127:0] pack_pt();
        logic [127:0] v;
        for (int i = 0; i < 16; i++) v = {v[119:0], m_pt[i]};
        return v;
    endfunction

    function automatic logic [127:0] pack_key();
        logic [127:0] v;
        for (int i = 0; i < 16; i++) v = {v[119:0], m_key[i]};
        return v;
    endfunction

    task automatic model_store(input int pos, input logic [7:0] b);
        if (pos < 16) m_pt[pos] = b;
        else          m_key[pos-16] = b;
    endtask

    always @(posedge clk) begin
        m_live = 1'b1;
        m_eto  = 1'b0;
        m_eov  = 1'b0;
        if (rst) begin
            m_cnt   = 0;
            m_quiet = 0;
            for (int i = 0; i < 16; i++) begin
                m_pt[i]  = 8'h00;
                m_key[i] = 8'h00;
            end
        end else if (m_cnt == 32) begin
            if (blk_ready) begin
                m_cnt = 0;
                if (rx_valid) begin
                    model_store(0, rx_data);
                    m_cnt   = 1;
                    m_quiet = 0;
                end
            end else if (rx_valid) begin
                m_eov = 1'b1;
            end
        end else if (rx_valid) begin
            model_store(m_cnt, rx_data);
            m_cnt++;
            m_quiet = 0;
        end else if (m_cnt > 0) begin
            m_quiet++;
            if (m_quiet == T) begin
                m_cnt   = 0;
                m_quiet = 0;
                m_eto   = 1'b1;
                for (int i = 0; i < 16; i++) begin
                    m_pt[i]  = 8'h00;
                    m_key[i] = 8'h00;
                end
            end
        end
    end

    // ---------------- scoreboard compare (every cycle) ----------------
    always @(posedge clk) begin
        #1;
        if (m_live) begin
            check("mdl_blk_valid",   {127'd0, blk_valid},   {127'd0, (m_cnt == 32)});
            check("mdl_busy",        {127'd0, busy},        {127'd0, (m_cnt > 0 && m_cnt < 32)});
            check("mdl_byte_cnt",    {122'd0, byte_cnt},    128'(m_cnt));
            check("mdl_err_timeout", {127'd0, err_timeout}, {127'd0, m_eto});
            check("mdl_err_overrun", {127'd0, err_overrun}, {127'd0, m_eov});
            check("mdl_plaintext",   blk_plaintext,         pack_pt());
            check("mdl_key",         blk_key,               pack_key());
        end
    end

    // ---------------- driver tasks (called at negedge) ----------------
    logic [255:0] nom_frame;

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_range(input int first, input int last);
        for (int i = first; i <= last; i++) send_byte(nom_frame[255-8*i -: 8]);
    endtask

    task automatic send_stub5();
        for (int i = 0; i < 5; i++) send_byte(8'(8'h11 + i));
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        nom_frame = {NOM_PT, NOM_KEY};
        repeat (3) @(negedge clk);
        check("rst_blk_valid", {127'd0, blk_valid}, 128'd0);
        check("rst_byte_cnt",  {122'd0, byte_cnt},  128'd0);
        check("rst_plaintext", blk_plaintext,       128'd0);
        check("rst_key",       blk_key,             128'd0);
        rst = 1'b0;
        @(negedge clk);

        // 1: nominal frame, ready held high
        blk_ready = 1'b1;
        send_range(0, 31);
        check("s1_valid",     {127'd0, blk_valid}, 128'd1);
        check("s1_byte_cnt",  {122'd0, byte_cnt},  128'd32);
        check("s1_plaintext", blk_plaintext,       NOM_PT);
        check("s1_key",       blk_key,             NOM_KEY);
        @(negedge clk);
        check("s1_valid_drop", {127'd0, blk_valid}, 128'd0);
        check("s1_cnt_zero",   {122'd0, byte_cnt},  128'd0);

        // 2: backpressure and overrun
        blk_ready = 1'b0;
        send_range(0, 31);
        repeat (2) @(negedge clk);
        check("s2_valid_held", {127'd0, blk_valid}, 128'd1);
        send_byte(8'hAA);
        check("s2_overrun",    {127'd0, err_overrun}, 128'd1);
        check("s2_cnt_32",     {122'd0, byte_cnt},    128'd32);
        check("s2_pt_stable",  blk_plaintext,         NOM_PT);
        @(negedge clk);
        check("s2_overrun_end", {127'd0, err_overrun}, 128'd0);
        blk_ready = 1'b1;
        @(negedge clk);
        check("s2_valid_drop", {127'd0, blk_valid}, 128'd0);
        check("s2_idle_busy",  {127'd0, busy},      128'd0);

        // 3: timeout after 5 bytes
        send_stub5();
        repeat (T - 1) @(negedge clk);
        check("s3_pre_expiry_busy", {127'd0, busy},        128'd1);
        check("s3_pre_expiry_err",  {127'd0, err_timeout}, 128'd0);
        @(negedge clk);
        check("s3_err_timeout", {127'd0, err_timeout}, 128'd1);
        check("s3_cnt_zero",    {122'd0, byte_cnt},    128'd0);
        check("s3_pt_cleared",  blk_plaintext,         128'd0);
        check("s3_busy",        {127'd0, busy},        128'd0);
        @(negedge clk);
        check("s3_err_end", {127'd0, err_timeout}, 128'd0);
        send_range(0, 31);
        check("s3_frame_pt",  blk_plaintext, NOM_PT);
        check("s3_frame_key", blk_key,       NOM_KEY);
        @(negedge clk);

        // 4a: byte lands exactly on the expiry cycle
        send_stub5();
        repeat (T - 1) @(negedge clk);
        send_byte(8'h66);
        check("s4_race_no_err", {127'd0, err_timeout}, 128'd0);
        check("s4_race_cnt",    {122'd0, byte_cnt},    128'd6);
        send_range(6, 31);
        check("s4_race_pt_head", {80'd0, blk_plaintext[127:80]}, 128'h111213141566);
        check("s4_race_valid",   {127'd0, blk_valid},            128'd1);
        @(negedge clk);

        // 4b: byte on the handshake cycle opens the next frame
        blk_ready = 1'b0;
        send_range(0, 31);
        blk_ready = 1'b1;
        send_byte(8'h5A);
        blk_ready = 1'b0;
        check("s4_hs_cnt",     {122'd0, byte_cnt},              128'd1);
        check("s4_hs_pt_byte", {120'd0, blk_plaintext[127:120]}, 128'h5A);
        check("s4_hs_overrun", {127'd0, err_overrun},           128'd0);
        check("s4_hs_valid",   {127'd0, blk_valid},             128'd0);
        blk_ready = 1'b1;
        send_range(1, 31);
        @(negedge clk);

        // 5: reset in the middle of a frame
        send_range(0, 19);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("s5_cnt",     {122'd0, byte_cnt},    128'd0);
        check("s5_busy",    {127'd0, busy},        128'd0);
        check("s5_pt",      blk_plaintext,         128'd0);
        check("s5_key",     blk_key,               128'd0);
        check("s5_err_to",  {127'd0, err_timeout}, 128'd0);
        check("s5_err_ov",  {127'd0, err_overrun}, 128'd0);
        send_range(0, 31);
        check("s5_frame_pt",  blk_plaintext, NOM_PT);
        check("s5_frame_key", blk_key,       NOM_KEY);
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
